uart_frame_echo: RTL and testbench

Parametrised successor to the RS422 port-2 command/echo controller. It buffers one received UART frame in an internal RAM and replays it byte by byte through a UART transmitter. End of frame is detected by a terminator character and/or a line-idle timeout. It adds a half-duplex driver-enable (`de`) sequence with guard times, so the same block serves RS422 and RS485 transceivers. It sits between the `uartrx`/`uarttx` pair of one port and runs in the 16x-baud clock domain.

---
 rtl/uart_frame_echo_if.sv | 23 ++
 rtl/uart_frame_echo.sv | 146 ++++++++++++++
 tb/tb_uart_frame_echo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_echo_if.sv
// Port bundle between the echo controller and one uartrx/uarttx pair.
// rx_valid is a one-cycle strobe with no back-pressure. tx_en is raised only while
// tx_idle is high. tx_data is valid with tx_en and holds until the next strobe.
interface uart_frame_echo_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              tx_idle;
   logic [DATA_W-1:0] tx_data;
   logic              tx_en;
   logic              de;

   modport master (
      input  rx_data, rx_valid, tx_idle,
      output tx_data, tx_en, de
   );

   modport slave (
      output rx_data, rx_valid, tx_idle,
      input  tx_data, tx_en, de
   );
endinterface

// File: rtl/uart_frame_echo.sv
// Buffers one received UART frame and replays it byte by byte, wrapping the echo
// in a half-duplex driver-enable window with guard times on both sides.
module uart_frame_echo #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 6,
   parameter logic [DATA_W-1:0] TERM_CHAR = 'h0A,
   parameter bit                USE_TERM  = 1'b1,
   parameter int                IDLE_TO   = 160,
   parameter int                DE_GUARD  = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   uart_frame_echo_if.master   bus,
   output logic                busy,
   output logic                frame_done,
   output logic [ADDR_W:0]     frame_len,
   output logic                overflow,
   output logic                rx_drop,
   output logic [2:0]          state_dbg
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int IW    = $clog2(IDLE_TO + 1);
   localparam int GW    = $clog2(DE_GUARD + 1);
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
   localparam logic [IW-1:0]   IDLE_END = IW'(IDLE_TO - 1);
   localparam logic [GW-1:0]   GRD_END  = GW'(DE_GUARD - 1);

   typedef enum logic [2:0] {
      S_RX, S_DE_ON, S_RD, S_STB, S_WBUSY, S_WIDLE, S_DE_OFF
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic [IW-1:0]     idle_cnt;
   logic [GW-1:0]     guard_cnt;
   logic              store;
   logic              term_hit;
   logic              timeout_hit;
   logic              wr_en;

   // The top bit of wptr marks a full buffer, so any further byte is dropped.
   always_comb begin
      store       = bus.rx_valid && !wptr[ADDR_W];
      term_hit    = USE_TERM && bus.rx_valid && (bus.rx_data == TERM_CHAR);
      timeout_hit = !bus.rx_valid && (wptr != '0) && (idle_cnt == IDLE_END);
      wr_en       = (state == S_RX) && store;
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[ADDR_W-1:0]] <= bus.rx_data;
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rptr[ADDR_W-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_RX;
         bus.tx_data <= '0;
         bus.tx_en   <= 1'b0;
         bus.de      <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_len   <= '0;
         overflow    <= 1'b0;
         rx_drop     <= 1'b0;
         wptr        <= '0;
         rptr        <= '0;
         idle_cnt    <= '0;
         guard_cnt   <= '0;
      end else begin
         bus.tx_en  <= 1'b0;
         frame_done <= 1'b0;
         rx_drop    <= bus.rx_valid && (state != S_RX);
         case (state)
            S_RX: begin
               if (bus.rx_valid) begin
                  idle_cnt <= '0;
                  if (store) begin
                     wptr <= wptr + PTR_ONE;
                     if (wptr == '0) overflow <= 1'b0;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else if ((wptr != '0) && (idle_cnt != '1)) begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
               if (term_hit || timeout_hit) begin
                  frame_len <= store ? (wptr + PTR_ONE) : wptr;
                  busy      <= 1'b1;
                  bus.de    <= 1'b1;
                  guard_cnt <= '0;
                  state     <= S_DE_ON;
               end
            end
            S_DE_ON: begin
               if (guard_cnt == GRD_END) begin
                  rptr  <= '0;
                  state <= S_RD;
               end else begin
                  guard_cnt <= guard_cnt + GW'(1);
               end
            end
            S_RD: state <= S_STB;
            S_STB: begin
               // RAM output is loaded every waiting cycle so tx_data is valid with tx_en.
               bus.tx_data <= rd_data;
               if (bus.tx_idle) begin
                  bus.tx_en <= 1'b1;
                  state     <= S_WBUSY;
               end
            end
            S_WBUSY: if (!bus.tx_idle) state <= S_WIDLE;
            S_WIDLE: begin
               if (bus.tx_idle) begin
                  rptr      <= rptr + PTR_ONE;
                  guard_cnt <= '0;
                  state     <= (rptr == frame_len - PTR_ONE) ? S_DE_OFF : S_RD;
               end
            end
            S_DE_OFF: begin
               if (guard_cnt == GRD_END) begin
                  bus.de     <= 1'b0;
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  wptr       <= '0;
                  rptr       <= '0;
                  idle_cnt   <= '0;
                  state      <= S_RX;
               end else begin
                  guard_cnt <= guard_cnt + GW'(1);
               end
            end
            default: state <= S_RX;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_echo.sv
// Directed bench for uart_frame_echo: three instances (default, timeout-only, 4-deep)
// share one stimulus bus; sel picks which one receives bytes and is observed.
module tb_uart_frame_echo;

   localparam int TX_BUSY = 20;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_idle_model;
   logic       tx_block;
   logic       tx_idle;
   int         sel;
   int         cyc = 0;
   int         en_count = 0;
   int         last_rise = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   logic       busy0, frame_done0, overflow0, rx_drop0;
   logic       busy1, frame_done1, overflow1, rx_drop1;
   logic       busy2, frame_done2, overflow2, rx_drop2;
   logic [6:0] frame_len0, frame_len1;
   logic [2:0] frame_len2;
   logic [2:0] state0, state1, state2;

   logic       tx_en_s, de_s, busy_s, frame_done_s, overflow_s, rx_drop_s;
   logic [7:0] tx_data_s;
   logic [6:0] frame_len_s;
   logic [2:0] state_s;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign tx_idle = tx_idle_model && !tx_block;

   uart_frame_echo_if #(.DATA_W(8)) bus0 ();
   uart_frame_echo_if #(.DATA_W(8)) bus1 ();
   uart_frame_echo_if #(.DATA_W(8)) bus2 ();

   assign bus0.rx_data  = rx_data;
   assign bus0.rx_valid = rx_valid && (sel == 0);
   assign bus0.tx_idle  = tx_idle;
   assign bus1.rx_data  = rx_data;
   assign bus1.rx_valid = rx_valid && (sel == 1);
   assign bus1.tx_idle  = tx_idle;
   assign bus2.rx_data  = rx_data;
   assign bus2.rx_valid = rx_valid && (sel == 2);
   assign bus2.tx_idle  = tx_idle;

   uart_frame_echo u0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0.master), .busy(busy0),
      .frame_done(frame_done0), .frame_len(frame_len0), .overflow(overflow0),
      .rx_drop(rx_drop0), .state_dbg(state0)
   );

   uart_frame_echo #(.USE_TERM(1'b0)) u1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.master), .busy(busy1),
      .frame_done(frame_done1), .frame_len(frame_len1), .overflow(overflow1),
      .rx_drop(rx_drop1), .state_dbg(state1)
   );

   uart_frame_echo #(.ADDR_W(2)) u2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2.master), .busy(busy2),
      .frame_done(frame_done2), .frame_len(frame_len2), .overflow(overflow2),
      .rx_drop(rx_drop2), .state_dbg(state2)
   );

   always_comb begin
      tx_en_s = bus0.tx_en; tx_data_s = bus0.tx_data; de_s = bus0.de;
      busy_s = busy0; frame_done_s = frame_done0; frame_len_s = frame_len0;
      overflow_s = overflow0; rx_drop_s = rx_drop0; state_s = state0;
      if (sel == 1) begin
         tx_en_s = bus1.tx_en; tx_data_s = bus1.tx_data; de_s = bus1.de;
         busy_s = busy1; frame_done_s = frame_done1; frame_len_s = frame_len1;
         overflow_s = overflow1; rx_drop_s = rx_drop1; state_s = state1;
      end else if (sel == 2) begin
         tx_en_s = bus2.tx_en; tx_data_s = bus2.tx_data; de_s = bus2.de;
         busy_s = busy2; frame_done_s = frame_done2; frame_len_s = {4'b0, frame_len2};
         overflow_s = overflow2; rx_drop_s = rx_drop2; state_s = state2;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      int cnt = 0;
      while (frame_done_s !== 1'b1 && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " frame_done"}, frame_done_s, 1);
      check({tag, " all bytes echoed"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, " frame_done single"}, frame_done_s, 0);
   endtask

   // Transmitter model: takes each strobe, goes busy for TX_BUSY cycles, scores the byte.
   initial begin
      tx_idle_model = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en_s === 1'b1) begin
            en_count++;
            check("tx_en expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_data", tx_data_s, exp_q.pop_front());
            tx_idle_model = 1'b0;
            @(negedge clk);
            check("tx_en width", tx_en_s, 0);
            repeat (TX_BUSY - 1) @(negedge clk);
            tx_idle_model = 1'b1;
            last_rise = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int base;
      reset_n  = 1'b0;
      rx_data  = '0;
      rx_valid = 1'b0;
      tx_block = 1'b0;
      sel      = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      check("reset tx_en", tx_en_s, 0);
      check("reset de", de_s, 0);
      check("reset busy", busy_s, 0);
      check("reset frame_done", frame_done_s, 0);
      check("reset frame_len", frame_len_s, 0);
      check("reset overflow", overflow_s, 0);
      check("reset tx_data", tx_data_s, 0);
      check("reset rx_drop", rx_drop_s, 0);
      check("reset state", state_s, 0);

      // "AB\n": terminator ends the frame, echo starts DE_GUARD+2 cycles later.
      exp_q = '{8'h41, 8'h42, 8'h0A};
      send_byte(8'h41, 8);
      send_byte(8'h42, 8);
      send_byte(8'h0A, 0);
      check("ab busy", busy_s, 1);
      check("ab de on", de_s, 1);
      check("ab frame_len", frame_len_s, 3);
      cnt = 0;
      while (tx_en_s !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("ab first strobe latency", cnt, 18);
      wait_done("ab");
      check("ab de off delay", cyc - 1 - last_rise, 17);
      check("ab de off", de_s, 0);
      check("ab overflow", overflow_s, 0);

      // Timeout-only instance: frame ends 160 cycles after the last byte.
      sel = 1;
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 4);
      send_byte(8'h05, 0);
      cnt = 0;
      while (busy_s !== 1'b1 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout end latency", cnt, 160);
      check("timeout frame_len", frame_len_s, 5);
      wait_done("timeout");

      // 4-deep instance: bytes past the buffer are dropped, terminator still ends frame.
      sel = 2;
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
      for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 4);
      send_byte(8'h0A, 0);
      check("ovf busy", busy_s, 1);
      check("ovf overflow set", overflow_s, 1);
      check("ovf frame_len", frame_len_s, 4);
      wait_done("ovf");
      check("ovf overflow sticky", overflow_s, 1);
      exp_q = '{8'h21, 8'h0A};
      send_byte(8'h21, 0);
      check("ovf cleared by first byte", overflow_s, 0);
      send_byte(8'h0A, 0);
      wait_done("ovf next");
      check("ovf next frame_len", frame_len_s, 2);

      // A byte arriving mid-echo is dropped and flagged.
      sel = 0;
      exp_q = '{8'h31, 8'h32, 8'h0A};
      send_byte(8'h31, 4);
      send_byte(8'h32, 4);
      send_byte(8'h0A, 4);
      send_byte(8'h55, 0);
      check("drop pulse", rx_drop_s, 1);
      @(negedge clk);
      check("drop pulse width", rx_drop_s, 0);
      wait_done("drop");
      check("drop frame_len", frame_len_s, 3);
      exp_q = '{8'h44, 8'h0A};
      send_byte(8'h44, 4);
      send_byte(8'h0A, 0);
      wait_done("after drop");
      check("after drop frame_len", frame_len_s, 2);

      // Reset between the 2nd and 3rd strobe of a 4-byte echo.
      exp_q = '{8'h61, 8'h62};
      base = en_count;
      send_byte(8'h61, 4);
      send_byte(8'h62, 4);
      send_byte(8'h63, 4);
      send_byte(8'h0A, 0);
      cnt = 0;
      while (en_count < base + 2 && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      check("mid reset two strobes", en_count - base, 2);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mid reset tx_en", tx_en_s, 0);
      check("mid reset de", de_s, 0);
      check("mid reset busy", busy_s, 0);
      check("mid reset state", state_s, 0);
      check("mid reset frame_len", frame_len_s, 0);
      base = en_count;
      repeat (200) @(negedge clk);
      check("mid reset no strobes", en_count - base, 0);
      exp_q = '{8'h5A, 8'h0A};
      send_byte(8'h5A, 4);
      send_byte(8'h0A, 0);
      wait_done("post reset");
      check("post reset frame_len", frame_len_s, 2);

      // Transmitter held busy: strobe withheld until tx_idle returns.
      tx_block = 1'b1;
      exp_q = '{8'h77, 8'h0A};
      base = en_count;
      send_byte(8'h77, 4);
      send_byte(8'h0A, 0);
      repeat (100) @(negedge clk);
      check("hold no strobe", en_count - base, 0);
      check("hold state stb", state_s, 3);
      check("hold tx_data", tx_data_s, 8'h77);
      tx_block = 1'b0;
      cnt = 0;
      while (tx_en_s !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("hold release latency", cnt, 1);
      wait_done("hold");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
